// File: rtl/lf_edge_period_detect.sv
// lf_edge_period_detect: LF envelope tracker, debounced hysteretic edge
// detector and edge-to-edge period meter. Define LF_ED_ENV_FREEZE_EN to add env_freeze.
module lf_edge_period_detect #(
   parameter int DW          = 8,
   parameter int DEBOUNCE    = 2,
   parameter int DECAY_SHIFT = 10,
   parameter int PW          = 16
) (
   input  logic          pck0,
   input  logic          rst,
   input  logic          sample_valid,
   input  logic [DW-1:0] sample,
   input  logic [DW-1:0] threshold,
   input  logic          toggle_mode,
`ifdef LF_ED_ENV_FREEZE_EN
   input  logic          env_freeze,
`endif
   output logic [DW-1:0] max_env,
   output logic [DW-1:0] min_env,
   output logic          edge_state,
   output logic          edge_toggle,
   output logic          edge_pulse,
   output logic          edge_out,
   output logic [PW-1:0] period,
   output logic          period_valid
);

   localparam int EW = DW + 1;
   localparam int CW = 4;
   localparam int TW = DECAY_SHIFT;

   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [EW-1:0] X_ONE  = EW'(1);
   localparam logic [EW-1:0] X_FULL = {1'b0, {DW{1'b1}}};
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [PW-1:0] P_MAX  = {PW{1'b1}};

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0] max_q, max_d;
   logic [DW-1:0] min_q, min_d;
   logic [TW-1:0] dcnt_q, dcnt_d;
   logic [CW-1:0] hi_cnt_q, hi_cnt_d;
   logic [CW-1:0] lo_cnt_q, lo_cnt_d;
   logic          toggle_q, toggle_d;
   logic          pulse_q, pulse_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [PW-1:0] period_q, period_d;
   logic          pvalid_q, pvalid_d;
   logic          first_q, first_d;

   logic          env_hold;
   logic          tick;

   logic [EW-1:0] max_x, min_x, thr_x, smp_x;
   logic [EW-1:0] mid_x, hi_raw, lo_sum, lo_raw;
   logic [EW-1:0] high_th, low_th, thr2_x;
   logic          armed;
   logic          ge_hi, le_lo;

   logic [CW-1:0] hi_inc, lo_inc;
   logic [CW-1:0] hi_nxt, lo_nxt;
   logic          rise, fall;
   logic [PW-1:0] pcnt_inc;

`ifdef LF_ED_ENV_FREEZE_EN
   assign env_hold = env_freeze;
`else
   assign env_hold = 1'b0;
`endif

   assign tick = &dcnt_q;

   // Envelope tracking with slow decay toward the opposite rail.
   always_comb begin
      max_d  = max_q;
      min_d  = min_q;
      dcnt_d = dcnt_q;
      if (sample_valid && !env_hold) begin
         dcnt_d = dcnt_q + T_ONE;
         if (sample > max_q) begin
            max_d = sample;
         end else if (tick && (max_x > (min_x + X_ONE))) begin
            max_d = max_q - D_ONE;
         end
         if (sample < min_q) begin
            min_d = sample;
         end else if (tick && ((min_x + X_ONE) < max_x)) begin
            min_d = min_q + D_ONE;
         end
      end
   end

   // Hysteresis thresholds and arming from the pre-update envelope.
   always_comb begin
      max_x  = {1'b0, max_q};
      min_x  = {1'b0, min_q};
      thr_x  = {1'b0, threshold};
      smp_x  = {1'b0, sample};
      mid_x  = (max_x + min_x) >> 1;
      hi_raw = (thr_x > max_x) ? '0 : (max_x - thr_x);
      high_th = (hi_raw > mid_x) ? hi_raw : mid_x;
      lo_sum = min_x + thr_x;
      lo_raw = (lo_sum > X_FULL) ? X_FULL : lo_sum;
      low_th = (lo_raw < mid_x) ? lo_raw : mid_x;
      thr2_x = thr_x << 1;
      armed  = (max_x > min_x) &&
               ((max_x - min_x) >= thr2_x);
      // high_th >= low_th always, so overlap only
      // happens when both are equal; high wins.
      ge_hi  = (smp_x >= high_th);
      le_lo  = (smp_x <= low_th) && !ge_hi;
   end

   // Saturating debounce run lengths and edge qualification.
   always_comb begin
      hi_inc = (hi_cnt_q >= DB_MAX) ? DB_MAX : (hi_cnt_q + C_ONE);
      lo_inc = (lo_cnt_q >= DB_MAX) ? DB_MAX : (lo_cnt_q + C_ONE);
      hi_nxt = ge_hi ? hi_inc : '0;
      lo_nxt = le_lo ? lo_inc : '0;
      rise   = sample_valid && armed &&
               (state_q == ST_LOW) && (hi_nxt == DB_MAX);
      fall   = sample_valid && armed &&
               (state_q == ST_HIGH) && (lo_nxt == DB_MAX);
      pcnt_inc = (pcnt_q == P_MAX) ? P_MAX : (pcnt_q + P_ONE);
   end

   // Edge FSM next state, strobes and period capture.
   always_comb begin
      state_d  = state_q;
      hi_cnt_d = hi_cnt_q;
      lo_cnt_d = lo_cnt_q;
      toggle_d = toggle_q;
      pulse_d  = 1'b0;
      pcnt_d   = pcnt_q;
      period_d = period_q;
      pvalid_d = 1'b0;
      first_d  = first_q;
      if (sample_valid) begin
         pcnt_d = pcnt_inc;
         if (!armed) begin
            hi_cnt_d = '0;
            lo_cnt_d = '0;
         end else if (rise || fall) begin
            state_d  = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
            toggle_d = !toggle_q;
            pulse_d  = 1'b1;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            period_d = pcnt_inc;
            pcnt_d   = '0;
            pvalid_d = !first_q;
            first_d  = 1'b0;
         end else begin
            hi_cnt_d = hi_nxt;
            lo_cnt_d = lo_nxt;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge pck0 or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LOW;
         max_q    <= '0;
         min_q    <= '1;
         dcnt_q   <= '0;
         hi_cnt_q <= '0;
         lo_cnt_q <= '0;
         toggle_q <= 1'b0;
         pulse_q  <= 1'b0;
         pcnt_q   <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
         first_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         max_q    <= max_d;
         min_q    <= min_d;
         dcnt_q   <= dcnt_d;
         hi_cnt_q <= hi_cnt_d;
         lo_cnt_q <= lo_cnt_d;
         toggle_q <= toggle_d;
         pulse_q  <= pulse_d;
         pcnt_q   <= pcnt_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
         first_q  <= first_d;
      end
   end

   assign max_env      = max_q;
   assign min_env      = min_q;
   assign edge_state   = (state_q == ST_HIGH);
   assign edge_toggle  = toggle_q;
   assign edge_pulse   = pulse_q;
   assign edge_out     = toggle_mode ? toggle_q : edge_state;
   assign period       = period_q;
   assign period_valid = pvalid_q;

endmodule

// File: doc/lf_edge_period_detect.md
Name: lf_edge_period_detect

Overview:
- Parametrised successor to the LF edge/peak detector, for the LF reader/sniffer paths.
- Takes filtered ADC samples and tracks the max/min envelope with slow decay.
- Detects high/low edges with hysteresis and a consecutive-sample debounce.
- Produces level, toggle and pulse outputs, plus an edge-to-edge period measured in samples, for the ARM via SSP frame/timer capture.

Parameters:
- DW, 8, sample/threshold/envelope width in bits.
- DEBOUNCE, 2, consecutive valid samples beyond a threshold needed to switch state (legal range 1..15).
- DECAY_SHIFT, 10, envelope decays by 1 LSB every 2^DECAY_SHIFT valid samples.
- PW, 16, period counter/output width in bits.

Ports:
- pck0  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  qualifies sample; one-cycle strobe.
- sample  in  DW  filtered ADC value, unsigned.
- threshold  in  DW  hysteresis offset from the envelope.
- toggle_mode  in  1  selects the edge_out source.
- max_env  out  DW  tracked maximum.
- min_env  out  DW  tracked minimum.
- edge_state  out  1  hysteretic level: 1 = high peak seen last.
- edge_toggle  out  1  inverts on every detected edge.
- edge_pulse  out  1  one-cycle strobe per detected edge.
- edge_out  out  1  toggle_mode ? edge_toggle : edge_state.
- period  out  PW  valid samples between the last two edges.
- period_valid  out  1  one-cycle strobe when period updates.

Behaviour:
- Reset values:
  - max_env=0, min_env=all-ones.
  - edge_state=0, edge_toggle=0, edge_pulse=0, period=0, period_valid=0.
  - Debounce counters=0, decay counter=0, period counter=0, first_edge flag=1.
- All state advances only on cycles with sample_valid=1. edge_pulse and period_valid are forced 0 on any other cycle.
- Envelope update, per valid sample:
  - If sample>max_env: max_env<=sample.
  - Else on a decay tick, if max_env>min_env+1: max_env<=max_env-1.
  - min_env is symmetric (sample<min_env loads it; on a tick, increments if min_env+1<max_env).
  - Decay tick = decay counter wraps at 2^DECAY_SHIFT-1. The decay counter is free-running on valid samples.
- Thresholds use the registered (pre-update) envelope, in DW+1 bits:
  - mid=(max_env+min_env)>>1.
  - high_th=max(max_env-threshold, mid), saturating at 0 before the comparison.
  - low_th=min(min_env+threshold, mid), saturating at all-ones.
- Armed: (max_env>min_env) and (max_env-min_env)>=2*threshold, with 2*threshold computed in DW+1 bits. When not armed, both debounce counters clear and no edge is possible.
- Debounce counters, per valid sample:
  - hi_cnt increments (saturating at DEBOUNCE) when sample>=high_th, else clears.
  - lo_cnt does the same for sample<=low_th.
  - If high_th==low_th, a sample equal to both counts for hi only.
- Edge rules:
  - Rising edge: edge_state==0 and hi_cnt reaches DEBOUNCE on this sample.
  - Falling edge: edge_state==1 and lo_cnt reaches DEBOUNCE on this sample.
  - DEBOUNCE=1 means the sample itself qualifies.
  - On an edge, in the cycle after the valid sample (latency 1): edge_state flips, edge_toggle flips, edge_pulse=1, and both debounce counters clear.
- Period counter:
  - Increments on every valid sample, saturating at 2^PW-1.
  - On an edge: period<=min(cnt+1, 2^PW-1), and cnt<=0.
  - period_valid=1 on the same cycle as edge_pulse, except on the first edge after reset, which only clears first_edge.
- edge_out is combinational from the registered edge_toggle/edge_state. A toggle_mode change takes effect immediately and alters no state.
- threshold changes apply from the next valid sample. No state is flushed.
- rst asserted mid-operation returns everything to reset values asynchronously. Release is synchronised externally.

Optional Feature:
- Macro: LF_ED_ENV_FREEZE_EN.
- When defined, adds input port env_freeze (1 bit). While env_freeze=1, max_env/min_env hold and the decay counter stops; edge detection continues on the frozen thresholds. Used during reader modulation so self-induced dips do not corrupt the envelope.
- When undefined, the port is absent and the envelope always updates.

Test Plan:
- Reset with rst=1, then feed samples 128 -> all outputs at reset values; after the first valid 128, max_env=min_env=128 and the block is not armed, so no edge.
- DW=8, threshold=20, DEBOUNCE=2, square wave 40/220 with 8 samples per half-period -> rising edge one cycle after the 2nd 220 sample. From the second edge on, period=8 with period_valid; first edge gives no period_valid; edge_toggle alternates each edge.
- Single-sample spike 40,40,220,40 with DEBOUNCE=2 after envelope 40/220 is established -> no edge_pulse; with DEBOUNCE=1 -> edge_pulse asserted.
- Constant 128 for 3*2^DECAY_SHIFT samples after a 40/220 envelope -> max_env decrements by 1 every 1024 samples, reaching 217; min_env reaches 43; edge_state unchanged.
- Toggle mode: toggle_mode=1, two consecutive high peaks separated by a dip that does not reach low_th -> edge_out unchanged, since no falling edge and no second rising edge. Switching toggle_mode mid-stream changes edge_out on the same cycle, with no edge_pulse.
- Edges 70000 samples apart with PW=16 -> period=65535, saturated. rst pulsed mid-stream -> period=0, first_edge set, and the next edge gives no period_valid.
